// File: rtl/zap_memory_main.sv
// Memory stage: captures load return data, aligns and extends it, flags data aborts,
// and registers the instruction for writeback. Holds on data stall, flushes on clear.
//   state | meaning
//   RUN   | normal operation, results pass through
//   SLEEP | data abort taken; squash instructions until writeback clears
module zap_memory_main #(
  parameter int PHY_REGS = 46,
  parameter int FLAG_WDT = 32,
  localparam int IW = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear_from_writeback,
  input  logic                i_data_stall,
  input  logic                i_data_mem_fault,
  input  logic [31:0]         i_mem_rd_data,
  input  logic                i_dav_ff,
  input  logic                i_uop_last,
  input  logic [31:0]         i_alu_result_ff,
  input  logic [FLAG_WDT-1:0] i_flags_ff,
  input  logic [IW-1:0]       i_destination_index_ff,
  input  logic [IW-1:0]       i_mem_srcdest_index_ff,
  input  logic                i_abt_ff,
  input  logic                i_irq_ff,
  input  logic                i_fiq_ff,
  input  logic                i_swi_ff,
  input  logic                i_und_ff,
  input  logic [31:0]         i_pc_plus_8_ff,
  input  logic                i_mem_load_ff,
  input  logic                i_data_wb_cyc_ff,
  input  logic [31:0]         i_mem_address_ff,
  input  logic                i_mem_unsigned_byte_enable_ff,
  input  logic                i_mem_signed_byte_enable_ff,
  input  logic                i_mem_unsigned_halfword_enable_ff,
  input  logic                i_mem_signed_halfword_enable_ff,
  output logic                o_dav_ff,
  output logic                o_uop_last,
  output logic [31:0]         o_alu_result_ff,
  output logic                o_mem_load_ff,
  output logic [31:0]         o_mem_rd_data_ff,
  output logic [FLAG_WDT-1:0] o_flags_ff,
  output logic [IW-1:0]       o_destination_index_ff,
  output logic [IW-1:0]       o_mem_srcdest_index_ff,
  output logic                o_abt_ff,
  output logic                o_irq_ff,
  output logic                o_fiq_ff,
  output logic                o_swi_ff,
  output logic                o_und_ff,
  output logic                o_dabt_ff,
  output logic [31:0]         o_fault_addr_ff,
  output logic [31:0]         o_pc_plus_8_ff
);

  typedef enum logic {RUN = 1'b0, SLEEP = 1'b1} state_t;

  state_t state, state_nxt;

  logic                fault;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [31:0]         rot_word;
  logic [31:0]         aligned;

  logic                dav_nxt, uop_last_nxt, mem_load_nxt, dabt_nxt;
  logic                abt_nxt, irq_nxt, fiq_nxt, swi_nxt, und_nxt;
  logic [31:0]         rd_data_nxt, fault_addr_nxt;

  assign fault = i_data_mem_fault & i_data_wb_cyc_ff & i_dav_ff;

  always_comb begin
    sel_byte = i_mem_rd_data[7:0];
    rot_word = i_mem_rd_data;
    case (i_mem_address_ff[1:0])
      2'd0: begin
        sel_byte = i_mem_rd_data[7:0];
        rot_word = i_mem_rd_data;
      end
      2'd1: begin
        sel_byte = i_mem_rd_data[15:8];
        rot_word = {i_mem_rd_data[7:0], i_mem_rd_data[31:8]};
      end
      2'd2: begin
        sel_byte = i_mem_rd_data[23:16];
        rot_word = {i_mem_rd_data[15:0], i_mem_rd_data[31:16]};
      end
      default: begin
        sel_byte = i_mem_rd_data[31:24];
        rot_word = {i_mem_rd_data[23:0], i_mem_rd_data[31:24]};
      end
    endcase
    sel_half = i_mem_address_ff[1] ? i_mem_rd_data[31:16] : i_mem_rd_data[15:0];

    if (i_mem_unsigned_byte_enable_ff)
      aligned = {24'd0, sel_byte};
    else if (i_mem_signed_byte_enable_ff)
      aligned = {{24{sel_byte[7]}}, sel_byte};
    else if (i_mem_unsigned_halfword_enable_ff)
      aligned = {16'd0, sel_half};
    else if (i_mem_signed_halfword_enable_ff)
      aligned = {{16{sel_half[15]}}, sel_half};
    else
      aligned = rot_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= RUN;
    else if (i_clear_from_writeback)
      state <= RUN;
    else if (!i_data_stall)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && fault)
      state_nxt = SLEEP;
  end

  always_comb begin
    dav_nxt        = i_dav_ff;
    uop_last_nxt   = i_uop_last;
    mem_load_nxt   = i_mem_load_ff & i_dav_ff;
    dabt_nxt       = 1'b0;
    abt_nxt        = i_abt_ff;
    irq_nxt        = i_irq_ff;
    fiq_nxt        = i_fiq_ff;
    swi_nxt        = i_swi_ff;
    und_nxt        = i_und_ff;
    rd_data_nxt    = o_mem_rd_data_ff;
    fault_addr_nxt = o_fault_addr_ff;
    case (state)
      RUN: begin
        if (fault) begin
          dav_nxt        = 1'b1;
          dabt_nxt       = 1'b1;
          mem_load_nxt   = 1'b0;
          fault_addr_nxt = i_mem_address_ff;
        end else if (i_mem_load_ff & i_dav_ff) begin
          rd_data_nxt = aligned;
        end
      end
      default: begin
        // Everything after the aborting instruction is squashed until the flush arrives.
        dav_nxt      = 1'b0;
        uop_last_nxt = 1'b0;
        mem_load_nxt = 1'b0;
        abt_nxt      = 1'b0;
        irq_nxt      = 1'b0;
        fiq_nxt      = 1'b0;
        swi_nxt      = 1'b0;
        und_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dav_ff               <= 1'b0;
      o_uop_last             <= 1'b0;
      o_alu_result_ff        <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_rd_data_ff       <= '0;
      o_flags_ff             <= '0;
      o_destination_index_ff <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      o_und_ff               <= 1'b0;
      o_dabt_ff              <= 1'b0;
      o_fault_addr_ff        <= '0;
      o_pc_plus_8_ff         <= '0;
    end else if (i_clear_from_writeback) begin
      o_dav_ff      <= 1'b0;
      o_uop_last    <= 1'b0;
      o_mem_load_ff <= 1'b0;
      o_dabt_ff     <= 1'b0;
      o_abt_ff      <= 1'b0;
      o_irq_ff      <= 1'b0;
      o_fiq_ff      <= 1'b0;
      o_swi_ff      <= 1'b0;
      o_und_ff      <= 1'b0;
      o_flags_ff    <= '0;
    end else if (!i_data_stall) begin
      o_dav_ff               <= dav_nxt;
      o_uop_last             <= uop_last_nxt;
      o_alu_result_ff        <= i_alu_result_ff;
      o_mem_load_ff          <= mem_load_nxt;
      o_mem_rd_data_ff       <= rd_data_nxt;
      o_flags_ff             <= i_flags_ff;
      o_destination_index_ff <= i_destination_index_ff;
      o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
      o_abt_ff               <= abt_nxt;
      o_irq_ff               <= irq_nxt;
      o_fiq_ff               <= fiq_nxt;
      o_swi_ff               <= swi_nxt;
      o_und_ff               <= und_nxt;
      o_dabt_ff              <= dabt_nxt;
      o_fault_addr_ff        <= fault_addr_nxt;
      o_pc_plus_8_ff         <= i_pc_plus_8_ff;
    end
  end

endmodule

// File: tb/tb_zap_memory_main.sv
// Directed bench for zap_memory_main: alignment, fault/sleep, stall, clear and reset.
module tb_zap_memory_main;

  logic        clk = 1'b0;
  logic        reset, clear, stall, mem_fault;
  logic [31:0] rd_data;
  logic        dav, uop_last;
  logic [31:0] alu_result;
  logic [31:0] flags;
  logic [5:0]  dest_idx, srcdest_idx;
  logic        abt, irq, fiq, swi, und;
  logic [31:0] pc_plus_8;
  logic        mem_load, wb_cyc;
  logic [31:0] mem_addr;
  logic        ub, sb, uh, sh;

  logic        o_dav, o_uop_last, o_mem_load, o_abt, o_irq, o_fiq, o_swi, o_und, o_dabt;
  logic [31:0] o_alu, o_rd, o_flags, o_fault_addr, o_pc;
  logic [5:0]  o_dest, o_srcdest;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zap_memory_main dut (
    .i_clk                             (clk),
    .i_reset                           (reset),
    .i_clear_from_writeback            (clear),
    .i_data_stall                      (stall),
    .i_data_mem_fault                  (mem_fault),
    .i_mem_rd_data                     (rd_data),
    .i_dav_ff                          (dav),
    .i_uop_last                        (uop_last),
    .i_alu_result_ff                   (alu_result),
    .i_flags_ff                        (flags),
    .i_destination_index_ff            (dest_idx),
    .i_mem_srcdest_index_ff            (srcdest_idx),
    .i_abt_ff                          (abt),
    .i_irq_ff                          (irq),
    .i_fiq_ff                          (fiq),
    .i_swi_ff                          (swi),
    .i_und_ff                          (und),
    .i_pc_plus_8_ff                    (pc_plus_8),
    .i_mem_load_ff                     (mem_load),
    .i_data_wb_cyc_ff                  (wb_cyc),
    .i_mem_address_ff                  (mem_addr),
    .i_mem_unsigned_byte_enable_ff     (ub),
    .i_mem_signed_byte_enable_ff       (sb),
    .i_mem_unsigned_halfword_enable_ff (uh),
    .i_mem_signed_halfword_enable_ff   (sh),
    .o_dav_ff                          (o_dav),
    .o_uop_last                        (o_uop_last),
    .o_alu_result_ff                   (o_alu),
    .o_mem_load_ff                     (o_mem_load),
    .o_mem_rd_data_ff                  (o_rd),
    .o_flags_ff                        (o_flags),
    .o_destination_index_ff            (o_dest),
    .o_mem_srcdest_index_ff            (o_srcdest),
    .o_abt_ff                          (o_abt),
    .o_irq_ff                          (o_irq),
    .o_fiq_ff                          (o_fiq),
    .o_swi_ff                          (o_swi),
    .o_und_ff                          (o_und),
    .o_dabt_ff                         (o_dabt),
    .o_fault_addr_ff                   (o_fault_addr),
    .o_pc_plus_8_ff                    (o_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sz = {ub, sb, uh, sh}
  task automatic ld(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] sz);
    dav = 1'b1; mem_load = 1'b1; wb_cyc = 1'b1; mem_fault = 1'b0;
    mem_addr = addr; rd_data = d;
    {ub, sb, uh, sh} = sz;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; stall = 1'b0; mem_fault = 1'b0;
    rd_data = 32'h0; dav = 1'b0; uop_last = 1'b0; alu_result = 32'h0; flags = 32'h0;
    dest_idx = 6'd0; srcdest_idx = 6'd0; abt = 0; irq = 0; fiq = 0; swi = 0; und = 0;
    pc_plus_8 = 32'h0; mem_load = 0; wb_cyc = 0; mem_addr = 32'h0;
    ub = 0; sb = 0; uh = 0; sh = 0;
    step(); step();
    chk("rst_dav", {31'd0, o_dav}, 32'd0);
    chk("rst_rd", o_rd, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_dabt", {31'd0, o_dabt}, 32'd0);
    reset = 1'b0;

    // LDRB
    ld(32'h1001, 32'hAABBCCDD, 4'b1000);
    alu_result = 32'h55; pc_plus_8 = 32'h108; flags = 32'hA000_0000;
    dest_idx = 6'd7; srcdest_idx = 6'd12; uop_last = 1'b1;
    step();
    chk("ldrb_rd", o_rd, 32'h0000_00CC);
    chk("ldrb_load", {31'd0, o_mem_load}, 32'd1);
    chk("ldrb_dav", {31'd0, o_dav}, 32'd1);
    chk("ldrb_alu", o_alu, 32'h55);
    chk("ldrb_pc", o_pc, 32'h108);
    chk("ldrb_flags", o_flags, 32'hA000_0000);
    chk("ldrb_srcdest", {26'd0, o_srcdest}, 32'd12);
    chk("ldrb_uop", {31'd0, o_uop_last}, 32'd1);

    ld(32'h2002, 32'h8001_1234, 4'b0001); step();
    chk("ldrsh_rd", o_rd, 32'hFFFF_8001);
    ld(32'h2002, 32'h8001_1234, 4'b0010); step();
    chk("ldrh_rd", o_rd, 32'h0000_8001);
    ld(32'h2000, 32'h8001_F234, 4'b0001); step();
    chk("ldrsh_lo_rd", o_rd, 32'hFFFF_F234);
    ld(32'h1003, 32'h8F00_0000, 4'b0100); step();
    chk("ldrsb_rd", o_rd, 32'hFFFF_FF8F);
    ld(32'h1003, 32'h8F00_0000, 4'b1100); step();
    chk("ub_over_sb", o_rd, 32'h0000_008F);
    ld(32'h3001, 32'h1122_3344, 4'b0000); step();
    chk("ldr_rot8", o_rd, 32'h4411_2233);
    ld(32'h3000, 32'h1122_3344, 4'b0000); step();
    chk("ldr_rot0", o_rd, 32'h1122_3344);
    ld(32'h3003, 32'h1122_3344, 4'b0000); step();
    chk("ldr_rot24", o_rd, 32'h2233_4411);

    // non-load valid: rd_data holds
    mem_load = 1'b0; rd_data = 32'h9999_9999; step();
    chk("noload_ml", {31'd0, o_mem_load}, 32'd0);
    chk("noload_rd", o_rd, 32'h2233_4411);
    // fault without bus cycle is ignored
    ld(32'h3000, 32'h0BAD_F00D, 4'b0000); mem_fault = 1'b1; wb_cyc = 1'b0; step();
    chk("nocyc_dabt", {31'd0, o_dabt}, 32'd0);
    chk("nocyc_rd", o_rd, 32'h0BAD_F00D);

    // fault
    ld(32'h4000, 32'hDEAD_BEEF, 4'b0000); mem_fault = 1'b1; swi = 1'b1; step();
    chk("flt_dav", {31'd0, o_dav}, 32'd1);
    chk("flt_dabt", {31'd0, o_dabt}, 32'd1);
    chk("flt_ml", {31'd0, o_mem_load}, 32'd0);
    chk("flt_addr", o_fault_addr, 32'h4000);
    chk("flt_rd", o_rd, 32'h0BAD_F00D);
    chk("flt_swi", {31'd0, o_swi}, 32'd1);
    ld(32'h5000, 32'h1234_5678, 4'b0000); irq = 1'b1; swi = 1'b0; step();
    chk("slp_dav", {31'd0, o_dav}, 32'd0);
    chk("slp_ml", {31'd0, o_mem_load}, 32'd0);
    chk("slp_irq", {31'd0, o_irq}, 32'd0);
    chk("slp_dabt", {31'd0, o_dabt}, 32'd0);
    chk("slp_rd", o_rd, 32'h0BAD_F00D);
    step();
    chk("slp2_dav", {31'd0, o_dav}, 32'd0);

    // clear together with stall: clear wins, data regs kept
    clear = 1'b1; stall = 1'b1; step();
    chk("clr_dav", {31'd0, o_dav}, 32'd0);
    chk("clr_flags", o_flags, 32'd0);
    chk("clr_rd", o_rd, 32'h0BAD_F00D);
    chk("clr_faddr", o_fault_addr, 32'h4000);
    clear = 1'b0; stall = 1'b0; irq = 1'b0;
    ld(32'h3000, 32'hCAFE_F00D, 4'b0000); step();
    chk("run_dav", {31'd0, o_dav}, 32'd1);
    chk("run_ml", {31'd0, o_mem_load}, 32'd1);
    chk("run_rd", o_rd, 32'hCAFE_F00D);

    // stall held for three cycles while inputs change
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld(32'h3001, 32'h1000_0000 + i, 4'b0000);
      alu_result = 32'h100 + i; dav = i[0];
      step();
      chk("stl_rd", o_rd, 32'hCAFE_F00D);
      chk("stl_alu", o_alu, 32'h55);
      chk("stl_dav", {31'd0, o_dav}, 32'd1);
    end
    stall = 1'b0;
    ld(32'h3002, 32'hAABB_CCDD, 4'b0000); alu_result = 32'h200; step();
    chk("rel_rd", o_rd, 32'hCCDD_AABB);
    chk("rel_alu", o_alu, 32'h200);

    // reset during SLEEP
    ld(32'h6000, 32'h0, 4'b0000); mem_fault = 1'b1; step();
    chk("flt2_dabt", {31'd0, o_dabt}, 32'd1);
    mem_fault = 1'b0; reset = 1'b1; step();
    chk("rst2_dav", {31'd0, o_dav}, 32'd0);
    chk("rst2_rd", o_rd, 32'd0);
    chk("rst2_faddr", o_fault_addr, 32'd0);
    chk("rst2_alu", o_alu, 32'd0);
    reset = 1'b0;
    ld(32'h7000, 32'h0123_4567, 4'b1000); step();
    chk("rst2_run_dav", {31'd0, o_dav}, 32'd1);
    chk("rst2_run_rd", o_rd, 32'h0000_0067);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
